register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port with
// same-cycle bypass, and a per-register pending scoreboard driving decode stall.
module register_file #(
  parameter int DATA_SIZE = 32,
  parameter int GPR_SIZE  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [GPR_SIZE-1:0]      read_address0,
  input  logic [GPR_SIZE-1:0]      read_address1,
  input  logic                     read_enable0,
  input  logic                     read_enable1,
  output logic [DATA_SIZE-1:0]     read_data0,
  output logic [DATA_SIZE-1:0]     read_data1,
  input  logic                     write_enable,
  input  logic [GPR_SIZE-1:0]      write_address,
  input  logic [DATA_SIZE-1:0]     write_data,
  input  logic                     reserve_enable,
  input  logic [GPR_SIZE-1:0]      reserve_address,
  output logic                     stall,
  output logic [(2**GPR_SIZE)-1:0] pending
);

  localparam int NREGS = 2 ** GPR_SIZE;

  logic [DATA_SIZE-1:0] regs_q [NREGS];
  logic [DATA_SIZE-1:0] regs_d [NREGS];
  logic [NREGS-1:0]     pending_q;
  logic [NREGS-1:0]     pending_d;

  logic bypass0;
  logic bypass1;
  logic hazard0;
  logic hazard1;

  // Decode handshake: a port is consumed only when read_enableN=1 and stall=0;
  // a same-cycle writeback to the read register resolves the hazard.
  assign bypass0 = write_enable && (write_address == read_address0);
  assign bypass1 = write_enable && (write_address == read_address1);

  assign read_data0 = bypass0 ? write_data : regs_q[read_address0];
  assign read_data1 = bypass1 ? write_data : regs_q[read_address1];

  assign hazard0 = read_enable0 && pending_q[read_address0] && !bypass0;
  assign hazard1 = read_enable1 && pending_q[read_address1] && !bypass1;
  assign stall   = hazard0 || hazard1;
  assign pending = pending_q;

  always_comb begin
    regs_d = regs_q;
    if (write_enable) begin
      regs_d[write_address] = write_data;
    end
  end

  // Clear before set so an accepted reservation wins over a same-cycle write.
  always_comb begin
    pending_d = pending_q;
    if (write_enable) begin
      pending_d[write_address] = 1'b0;
    end
    if (reserve_enable && !stall) begin
      pending_d[reserve_address] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clock;
  logic          reset;
  logic [AW-1:0] read_address0;
  logic [AW-1:0] read_address1;
  logic          read_enable0;
  logic          read_enable1;
  logic [DW-1:0] read_data0;
  logic [DW-1:0] read_data1;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          reserve_enable;
  logic [AW-1:0] reserve_address;
  logic          stall;
  logic [NR-1:0] pending;

  register_file #(.DATA_SIZE(DW), .GPR_SIZE(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .read_address0   (read_address0),
    .read_address1   (read_address1),
    .read_enable0    (read_enable0),
    .read_enable1    (read_enable1),
    .read_data0      (read_data0),
    .read_data1      (read_data1),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address),
    .stall           (stall),
    .pending         (pending)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [DW-1:0] m_mem [NR];
  bit            m_pend [NR];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
    if (write_enable && write_address == ra) return write_data;
    return m_mem[ra];
  endfunction

  function automatic bit m_hazard(input bit re, input logic [AW-1:0] ra);
    return re && m_pend[ra] && !(write_enable && write_address == ra);
  endfunction

  function automatic logic m_stall();
    return m_hazard(read_enable0, read_address0) || m_hazard(read_enable1, read_address1);
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // compare every output with the model once inputs have settled
  task automatic settle();
    #1;
    chk("read_data0", read_data0, m_read(read_address0));
    chk("read_data1", read_data1, m_read(read_address1));
    chk("stall", {31'b0, stall}, {31'b0, m_stall()});
    chk("pending", {24'b0, pending}, {24'b0, m_pending()});
  endtask

  // advance one clock and apply the same edge to the model
  task automatic clk();
    logic st;
    st = m_stall();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (write_enable) m_mem[write_address] = write_data;
      for (int i = 0; i < NR; i++) begin
        if (reserve_enable && !st && reserve_address == i) m_pend[i] = 1'b1;
        else if (write_enable && write_address == i)        m_pend[i] = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    reset          = 1'b0;
    read_enable0   = 1'b0;
    read_enable1   = 1'b0;
    write_enable   = 1'b0;
    reserve_enable = 1'b0;
  endtask

  initial begin
    idle();
    read_address0   = '0;
    read_address1   = '0;
    write_address   = '0;
    write_data      = '0;
    reserve_address = '0;
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = 'x;
      m_pend[i] = 1'b0;
    end
    @(negedge clock);
    reset = 1'b1;
    clk();
    clk();
    reset = 1'b0;

    // reset state on every address of both ports
    read_enable0 = 1'b1;
    read_enable1 = 1'b1;
    for (int a = 0; a < NR; a++) begin
      read_address0 = AW'(a);
      read_address1 = AW'(NR - 1 - a);
      settle();
      chk("rst_rd0", read_data0, 32'h0);
      chk("rst_rd1", read_data1, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_pending", {24'b0, pending}, 32'h0);
      clk();
    end
    idle();

    // write with bypass, then array read
    write_enable = 1'b1; write_address = 3'd5; write_data = 32'hDEADBEEF;
    read_address0 = 3'd5;
    settle();
    chk("bypass_rd0", read_data0, 32'hDEADBEEF);
    clk();
    write_enable = 1'b0;
    settle();
    chk("array_rd0", read_data0, 32'hDEADBEEF);
    clk();

    // reserve reg3, hazard, then resolving writeback
    reserve_enable = 1'b1; reserve_address = 3'd3;
    settle();
    clk();
    reserve_enable = 1'b0;
    read_enable1 = 1'b1; read_address1 = 3'd3;
    settle();
    chk("raw_stall", {31'b0, stall}, 32'h1);
    chk("raw_pending", {24'b0, pending}, 32'h08);
    clk();
    write_enable = 1'b1; write_address = 3'd3; write_data = 32'h12;
    settle();
    chk("wb_stall", {31'b0, stall}, 32'h0);
    chk("wb_rd1", read_data1, 32'h12);
    clk();
    idle();
    settle();
    chk("wb_pending", {24'b0, pending}, 32'h00);
    clk();

    // reservation and write to the same register in one cycle
    reserve_enable = 1'b1; reserve_address = 3'd2;
    write_enable = 1'b1; write_address = 3'd2; write_data = 32'h55;
    settle();
    clk();
    idle();
    read_address0 = 3'd2;
    settle();
    chk("rw_rd0", read_data0, 32'h55);
    chk("rw_pending", {24'b0, pending}, 32'h04);
    clk();

    // reservation ignored while stalled; disabled port never stalls
    reserve_enable = 1'b1; reserve_address = 3'd4;
    settle();
    clk();
    read_enable0 = 1'b1; read_address0 = 3'd4;
    reserve_address = 3'd6;
    settle();
    chk("st_stall", {31'b0, stall}, 32'h1);
    clk();
    reserve_enable = 1'b0;
    settle();
    chk("st_pending", {24'b0, pending}, 32'h14);
    read_enable0 = 1'b0;
    settle();
    chk("noen_stall", {31'b0, stall}, 32'h0);
    clk();

    // mid-operation reset discards reservations and data
    idle();
    reserve_enable = 1'b1; reserve_address = 3'd1;
    write_enable = 1'b1; write_address = 3'd1; write_data = 32'h11;
    settle();
    clk();
    reserve_address = 3'd7; write_address = 3'd7; write_data = 32'h77;
    settle();
    clk();
    reset = 1'b1; reserve_address = 3'd0; write_address = 3'd0; write_data = 32'hFF;
    clk();
    idle();
    read_enable0 = 1'b1; read_address0 = 3'd1;
    read_enable1 = 1'b1; read_address1 = 3'd7;
    settle();
    chk("mr_pending", {24'b0, pending}, 32'h00);
    chk("mr_stall", {31'b0, stall}, 32'h0);
    chk("mr_rd0", read_data0, 32'h0);
    chk("mr_rd1", read_data1, 32'h0);
    clk();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      read_enable0    = $urandom_range(0, 1);
      read_enable1    = $urandom_range(0, 1);
      read_address0   = AW'($urandom_range(0, NR - 1));
      read_address1   = AW'($urandom_range(0, NR - 1));
      write_enable    = ($urandom_range(0, 2) == 0);
      write_address   = AW'($urandom_range(0, NR - 1));
      write_data      = $urandom;
      reserve_enable  = ($urandom_range(0, 2) == 0);
      reserve_address = AW'($urandom_range(0, NR - 1));
      settle();
      clk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
